fsk_rx_ctrl: RTL and testbench
==============================

Name: fsk_rx_ctrl

Overview:
Synchronous receive controller for the 2-FSK link, running on the system clock.
- Generates the bit-period timing and counts FSK edges per bit to slice bits.
- Hunts for a sync word, then assembles the following 16-bit payload.
- Hands the payload to the downstream consumer over a valid/ready handshake, with overrun detection.
- Sits between the FSK pin and the frame/decoder logic.

Parameters:
CLK_PER_BIT, 64, system clocks per data bit (>=8)
THRESH, 4, edge count strictly greater than THRESH slices as 1
SYNC_WORD, 8'hD5, sync pattern, MSB received first (must be nonzero)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
en  input  1  receiver enable
fsk_in  input  1  asynchronous FSK signal
data_out  output  16  received payload, MSB first on the line
data_valid  output  1  payload available
data_ready  input  1  consumer accepts payload
busy  output  1  high while in DATA state
overrun  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE; timer, edge counter, shift registers and bit index all 0; data_out=0, data_valid=0, busy=0, overrun=0. Reset mid-frame discards everything.
- Input conditioning: two-flop synchronizer on fsk_in. Rising edge = s1 & ~s2, so detection adds 2-3 cycles of latency.
- Bit timer:
  - counts 0..CLK_PER_BIT-1 and wraps; bit_strobe when the count == CLK_PER_BIT-1.
  - held at 0 in IDLE; starts at 0 on the cycle after leaving IDLE.
- Edge counter:
  - 8 bits, saturating at 255; counts detected edges within the current period.
  - An edge in the strobe cycle counts toward the current bit.
  - At strobe: sliced_bit = (count incl. strobe-cycle edge) > THRESH; counter then clears to 0.
- FSM:
  - IDLE: leave to HUNT when en==1.
  - HUNT: on each strobe, shift sliced_bit into an 8-bit sync register (LSB in); a fill counter saturates at 8. When fill==8 and sync_reg==SYNC_WORD after a shift, go to DATA with bit_idx=0.
  - DATA: on each strobe, shift sliced_bit into a 16-bit payload register (LSB in) and increment bit_idx. The 16th strobe completes the frame; go back to HUNT with sync_reg and fill cleared.
  - en==0 in any state: go to IDLE on the next edge, discard any partial frame and clear the timer. data_valid/data_out are not affected.
- Delivery on frame completion (the edge that ends the 16th strobe cycle):
  - If data_valid==0, or data_valid==1 and data_ready==1 in the same cycle: data_out is loaded with the payload and data_valid=1.
  - Otherwise the payload is dropped, data_out/data_valid are held, and overrun pulses high for 1 cycle.
- Handshake:
  - data_valid clears on the edge where data_valid && data_ready, unless a new load happens on the same edge (then it stays 1 with the new data).
  - data_out is stable while data_valid==1.
- busy = (state==DATA), registered with the state.

Decomposition:
- Shared package (fsk_pkg): state encoding (IDLE, HUNT, DATA), default CLK_PER_BIT, THRESH and SYNC_WORD, payload width constant 16.
- One sub-module, fsk_bit_slicer: synchronizer, edge detect, bit timer, edge counter. Outputs bit_strobe and sliced_bit; inputs clk, rst, run.
- fsk_rx_ctrl keeps the FSM, shift registers and handshake.

Test Plan:
Stimulus uses CLK_PER_BIT=64, THRESH=4. A "1" bit is 8 evenly spaced fsk_in pulses per period; a "0" bit is 2 pulses.
1. Hold rst=0 for 3 cycles with en=1 and fsk_in toggling -> all outputs 0, state IDLE; after release, busy stays 0 until sync is seen.
2. en=1, data_ready=1; send 0x55, then 0xD5, then 0xBEEF -> busy rises after the sync strobe. data_out=16'hBEEF and data_valid=1 one cycle after the 16th data strobe; data_valid drops on the next edge; overrun never asserts.
3. Threshold: frame 0xD5 with a payload whose bits alternate 5 pulses and 4 pulses -> data_out=16'hAAAA; a payload of all 255+ pulses per bit -> 16'hFFFF, counter saturates with no wrap.
4. Backpressure: data_ready=0; send frames 0x1234, then 0x5678 -> data_out stays 16'h1234 with data_valid=1, overrun pulses exactly once at the end of the second frame. Raise data_ready -> data_valid=0 next cycle.
5. Drop en after 8 data bits -> IDLE next edge, busy=0, no data_valid. Re-enable and send a full frame 0xCAFE -> data_out=16'hCAFE.
6. Assert rst=0 for 1 cycle mid-DATA while data_valid=1 -> next edge: data_valid=0, data_out=0, busy=0, state IDLE.

Source files
------------

// File: rtl/fsk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsk_pkg
// Description : Shared definitions for the 2-FSK receive path: controller
//               state encoding, default timing/threshold/sync constants and
//               the payload width.
// Revision    : 1.0  initial release
// ============================================================================
package fsk_pkg;

  // Receive controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2
  } fsk_state_t;

  localparam int          DEF_CLK_PER_BIT = 64;
  localparam int          DEF_THRESH      = 4;
  localparam logic [7:0]  DEF_SYNC_WORD   = 8'hD5;
  localparam int          PAYLOAD_W       = 16;
  localparam int          SYNC_W          = 8;

  // 8-bit increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : fsk_pkg
`default_nettype wire

// File: rtl/fsk_bit_slicer.sv
`default_nettype none
// ============================================================================
// Module      : fsk_bit_slicer
// Description : Synchronises the FSK pin, detects rising edges, runs the
//               bit-period timer and counts edges per period. At the end of
//               each period it emits bit_strobe together with the sliced bit.
// Revision    : 1.0  initial release
// Ports       :
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   run        in   timer/counter run; held at zero while low
//   fsk_in     in   asynchronous FSK signal
//   bit_strobe out  high in the last cycle of each bit period
//   sliced_bit out  decided bit, valid while bit_strobe is high
// ============================================================================
module fsk_bit_slicer
  import fsk_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int THRESH      = DEF_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic fsk_in,
  output logic bit_strobe,
  output logic sliced_bit
);

  localparam int              TIMER_W  = $clog2(CLK_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_PER_BIT - 1);
  localparam logic [7:0]      THRESH_C = 8'(THRESH);

  logic               sync1;
  logic               sync2;
  logic               rise;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         edge_cnt;
  logic [7:0]         cnt_incl;

  // Two-flop synchroniser; the edge is taken between the two stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= fsk_in;
      sync2 <= sync1;
    end
  end

  assign rise       = sync1 & ~sync2;
  assign bit_strobe = run && (timer == TIMER_LAST);

  // An edge landing in the strobe cycle still belongs to the current bit,
  // so the decision uses the count including that edge.
  assign cnt_incl   = rise ? sat_inc8(edge_cnt) : edge_cnt;
  assign sliced_bit = (cnt_incl > THRESH_C);

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      edge_cnt <= 8'd0;
    end else if (bit_strobe) begin
      edge_cnt <= 8'd0;
    end else begin
      edge_cnt <= cnt_incl;
    end
  end

endmodule : fsk_bit_slicer
`default_nettype wire

// File: rtl/fsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fsk_rx_ctrl
// Description : 2-FSK receive controller. Slices bits from the FSK pin,
//               hunts for the sync word, assembles the 16-bit payload and
//               hands it downstream over valid/ready with overrun detection.
// Revision    : 1.0  initial release
// Ports       :
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   en         in   receiver enable
//   fsk_in     in   asynchronous FSK signal
//   data_out   out  received payload (MSB first on the line)
//   data_valid out  payload available
//   data_ready in   consumer accepts payload
//   busy       out  high while in DATA state
//   overrun    out  one-cycle pulse when a completed frame is dropped
// ============================================================================
module fsk_rx_ctrl
  import fsk_pkg::*;
#(
  parameter int         CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int         THRESH      = DEF_THRESH,
  parameter logic [7:0] SYNC_WORD   = DEF_SYNC_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fsk_in,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_W - 1);
  localparam logic [3:0] FILL_MAX = 4'(SYNC_W);

  fsk_state_t           state;
  fsk_state_t           state_n;
  logic [SYNC_W-1:0]    sync_reg;
  logic [SYNC_W-1:0]    sync_n;
  logic [3:0]           fill;
  logic [3:0]           fill_n;
  logic [PAYLOAD_W-1:0] payload;
  logic [PAYLOAD_W-1:0] payload_n;
  logic [4:0]           bit_idx;
  logic [4:0]           bit_idx_n;
  logic [PAYLOAD_W-1:0] data_out_n;
  logic                 data_valid_n;
  logic                 busy_n;
  logic                 overrun_n;

  logic                 run;
  logic                 bit_strobe;
  logic                 sliced_bit;
  logic [SYNC_W-1:0]    sync_shift;
  logic [PAYLOAD_W-1:0] payload_shift;

  // Gating with en clears the timer on the same edge that returns to IDLE
  assign run = en && (state != IDLE);

  fsk_bit_slicer #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .THRESH      (THRESH)
  ) u_slicer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .fsk_in     (fsk_in),
    .bit_strobe (bit_strobe),
    .sliced_bit (sliced_bit)
  );

  assign sync_shift    = {sync_reg[SYNC_W-2:0], sliced_bit};
  assign payload_shift = {payload[PAYLOAD_W-2:0], sliced_bit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sync_reg   <= '0;
      fill       <= '0;
      payload    <= '0;
      bit_idx    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      sync_reg   <= sync_n;
      fill       <= fill_n;
      payload    <= payload_n;
      bit_idx    <= bit_idx_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    sync_n       = sync_reg;
    fill_n       = fill;
    payload_n    = payload;
    bit_idx_n    = bit_idx;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    overrun_n    = 1'b0;

    // Consumer handshake; a same-edge load below overrides this clear
    if (data_valid && data_ready) begin
      data_valid_n = 1'b0;
    end

    if (!en) begin
      // Disable discards any partial frame but leaves the output register alone
      state_n   = IDLE;
      sync_n    = '0;
      fill_n    = '0;
      payload_n = '0;
      bit_idx_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = HUNT;
          sync_n    = '0;
          fill_n    = '0;
          payload_n = '0;
          bit_idx_n = '0;
        end

        HUNT: begin
          if (bit_strobe) begin
            sync_n = sync_shift;
            fill_n = (fill == FILL_MAX) ? fill : fill + 4'd1;
            // Require a full window so a zero-filled register never matches early
            if ((fill_n == FILL_MAX) && (sync_n == SYNC_WORD)) begin
              state_n   = DATA;
              bit_idx_n = '0;
              payload_n = '0;
            end
          end
        end

        DATA: begin
          if (bit_strobe) begin
            payload_n = payload_shift;
            bit_idx_n = bit_idx + 5'd1;
            if (bit_idx == LAST_IDX) begin
              state_n   = HUNT;
              sync_n    = '0;
              fill_n    = '0;
              bit_idx_n = '0;
              if (!data_valid || data_ready) begin
                data_out_n   = payload_shift;
                data_valid_n = 1'b1;
              end else begin
                overrun_n = 1'b1;
              end
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n == DATA);
  end

endmodule : fsk_rx_ctrl
`default_nettype wire

// File: tb/tb_fsk_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsk_rx_ctrl
// Description : Directed self-checking bench for fsk_rx_ctrl. Instance A runs
//               at 64 clocks/bit; instance B runs at 520 clocks/bit so a bit
//               can carry more than 255 edges (counter saturation).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fsk_rx_ctrl;
  import fsk_pkg::*;

  localparam int PER_A = 64;
  localparam int PER_B = 520;

  logic        clk;
  logic        rst;
  logic        en_a, fsk_a, ready_a, valid_a, busy_a, ovr_a;
  logic [15:0] dout_a;
  logic        en_b, fsk_b, ready_b, valid_b, busy_b, ovr_b;
  logic [15:0] dout_b;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;
  int ovr_base;

  fsk_rx_ctrl #(.CLK_PER_BIT(PER_A), .THRESH(4), .SYNC_WORD(8'hD5)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .fsk_in(fsk_a),
    .data_out(dout_a), .data_valid(valid_a), .data_ready(ready_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  fsk_rx_ctrl #(.CLK_PER_BIT(PER_B), .THRESH(4), .SYNC_WORD(8'hD5)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .fsk_in(fsk_b),
    .data_out(dout_b), .data_valid(valid_b), .data_ready(ready_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Overrun pulses counted away from the active edge
  always @(negedge clk) begin
    if (ovr_a === 1'b1) ovr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Level of an n-pulse bit at cycle j of a period of length per
  function automatic logic lvl(input int j, input int n, input int per);
    int step;
    if (n == 0) return 1'b0;
    step = per / n;
    if ((j / step) >= n) return 1'b0;
    return ((j % step) < (step / 2));
  endfunction

  // Sends val[nb-1:0] MSB first; each loop cycle drives the level for timer j.
  // Returns during the strobe cycle of the last bit.
  task automatic send_bits(input logic [15:0] val, input int nb, input int n1,
                           input int n0, input int per, input bit to_b);
    for (int i = nb - 1; i >= 0; i--) begin
      for (int j = 0; j < per; j++) begin
        @(posedge clk); #1;
        if (to_b) fsk_b = lvl(j, val[i] ? n1 : n0, per);
        else      fsk_a = lvl(j, val[i] ? n1 : n0, per);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic stop_a();
    en_a = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; en_a = 1'b1; fsk_a = 1'b0; ready_a = 1'b1;
    en_b = 1'b0; fsk_b = 1'b0; ready_b = 1'b1;

    // 1. reset with en high and the pin toggling
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      fsk_a = ~fsk_a;
    end
    check("rst_dout",  32'(dout_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_busy",  32'(busy_a), 32'h0);
    check("rst_ovr",   32'(ovr_a), 32'h0);
    check("rst_state", 32'(dut_a.state), 32'(IDLE));
    rst = 1'b1; fsk_a = 1'b0;
    repeat (100) tick();
    check("nosync_busy", 32'(busy_a), 32'h0);
    stop_a();

    // 2. preamble, sync, payload BEEF with ready high
    en_a = 1'b1;
    send_bits(16'h0055, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    check("sync_busy_pre", 32'(busy_a), 32'h0);
    send_bits(16'h0001, 1, 8, 2, PER_A, 1'b0);
    check("sync_busy_post", 32'(busy_a), 32'h1);
    send_bits(16'h3EEF, 15, 8, 2, PER_A, 1'b0);
    check("beef_valid_pre", 32'(valid_a), 32'h0);
    tick();
    check("beef_valid", 32'(valid_a), 32'h1);
    check("beef_dout",  32'(dout_a), 32'hBEEF);
    check("beef_busy",  32'(busy_a), 32'h0);
    tick();
    check("beef_valid_clr", 32'(valid_a), 32'h0);
    check("beef_no_ovr", 32'(ovr_cnt), 32'h0);
    stop_a();

    // 3. threshold: 5 pulses -> 1, 4 pulses -> 0
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'hAAAA, 16, 5, 4, PER_A, 1'b0);
    tick();
    check("thr_dout",  32'(dout_a), 32'hAAAA);
    check("thr_valid", 32'(valid_a), 32'h1);
    stop_a();

    // 3b. 260 edges per bit: a wrapping counter would read 4 and slice 0
    en_b = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_B, 1'b1);
    send_bits(16'hFFFF, 16, 260, 0, PER_B, 1'b1);
    tick();
    check("sat_dout",  32'(dout_b), 32'hFFFF);
    check("sat_valid", 32'(valid_b), 32'h1);
    en_b = 1'b0;

    // 4. backpressure and overrun
    ready_a = 1'b0;
    ovr_base = ovr_cnt;
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h1234, 16, 8, 2, PER_A, 1'b0);
    tick();
    check("bp1_dout",  32'(dout_a), 32'h1234);
    check("bp1_valid", 32'(valid_a), 32'h1);
    stop_a();
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h5678, 16, 8, 2, PER_A, 1'b0);
    check("bp2_ovr_none", 32'(ovr_cnt - ovr_base), 32'h0);
    tick();
    check("bp2_ovr_hi", 32'(ovr_a), 32'h1);
    check("bp2_dout",   32'(dout_a), 32'h1234);
    check("bp2_valid",  32'(valid_a), 32'h1);
    tick();
    check("bp2_ovr_lo", 32'(ovr_a), 32'h0);
    ready_a = 1'b1;
    tick();
    check("bp_valid_clr", 32'(valid_a), 32'h0);
    check("bp_ovr_once", 32'(ovr_cnt - ovr_base), 32'h1);
    stop_a();

    // 5. drop en mid-payload, then a full frame
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h00FF, 8, 8, 2, PER_A, 1'b0);
    check("abort_busy_pre", 32'(busy_a), 32'h1);
    en_a = 1'b0;
    tick();
    check("abort_busy",  32'(busy_a), 32'h0);
    check("abort_state", 32'(dut_a.state), 32'(IDLE));
    repeat (70) tick();
    check("abort_valid", 32'(valid_a), 32'h0);
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'hCAFE, 16, 8, 2, PER_A, 1'b0);
    tick();
    check("cafe_dout",  32'(dout_a), 32'hCAFE);
    check("cafe_valid", 32'(valid_a), 32'h1);
    tick();
    stop_a();

    // 6. reset mid-DATA with a pending payload
    ready_a = 1'b0;
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h0F0F, 16, 8, 2, PER_A, 1'b0);
    tick();
    check("pend_dout", 32'(dout_a), 32'h0F0F);
    stop_a();
    en_a = 1'b1;
    send_bits(16'h00D5, 8, 8, 2, PER_A, 1'b0);
    send_bits(16'h000A, 4, 8, 2, PER_A, 1'b0);
    check("mid_busy",  32'(busy_a), 32'h1);
    check("mid_valid", 32'(valid_a), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_valid", 32'(valid_a), 32'h0);
    check("mrst_dout",  32'(dout_a), 32'h0);
    check("mrst_busy",  32'(busy_a), 32'h0);
    check("mrst_state", 32'(dut_a.state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fsk_rx_ctrl
`default_nettype wire
